// File: rtl/enemy_pkg.sv
// Constants shared by the spawner, the enemy pool and the renderer.
// Also holds the popcount helper that derives the live enemy count from the slot mask.
package enemy_pkg;
  localparam int NUM_ENEMIES = 8;
  localparam int X_W         = 10;
  localparam int Y_W         = 9;
  localparam int SCREEN_W    = 640;
  localparam int SCREEN_H    = 480;
  localparam int IDX_W       = 3;
  localparam int CNT_W       = 4;

  function automatic logic [CNT_W-1:0] popcount(input logic [NUM_ENEMIES-1:0] mask);
    logic [CNT_W-1:0] n;
    n = '0;
    for (int i = 0; i < NUM_ENEMIES; i++) begin
      n = n + CNT_W'(mask[i]);
    end
    return n;
  endfunction
endpackage

// File: rtl/enemy_pool_if.sv
// Bundles the game-side controls and the slot-table outputs of the enemy pool.
// The master modport is the game/collision side; the slave modport is the pool itself.
interface enemy_pool_if;
  import enemy_pkg::*;

  logic                         enable;
  logic                         spawn;
  logic [3:0]                   random_number;
  logic                         kill_valid;
  logic [IDX_W-1:0]             kill_idx;
  logic [NUM_ENEMIES-1:0]       enemy_active;
  logic [NUM_ENEMIES*X_W-1:0]   enemy_x_flat;
  logic [NUM_ENEMIES*Y_W-1:0]   enemy_y_flat;
  logic [CNT_W-1:0]             enemy_count;
  logic                         escaped;

  modport master (
    output enable, spawn, random_number, kill_valid, kill_idx,
    input  enemy_active, enemy_x_flat, enemy_y_flat, enemy_count, escaped
  );

  modport slave (
    input  enable, spawn, random_number, kill_valid, kill_idx,
    output enemy_active, enemy_x_flat, enemy_y_flat, enemy_count, escaped
  );
endinterface

// File: rtl/free_slot_finder.sv
// Combinational priority picker: lowest-index clear bit of the active mask.
// found_o is low only when every slot is live.
module free_slot_finder
  import enemy_pkg::*;
(
  input  logic [NUM_ENEMIES-1:0] active_i,
  output logic [IDX_W-1:0]       idx_o,
  output logic                   found_o
);

  always_comb begin
    idx_o   = '0;
    found_o = 1'b0;
    // Scan downwards so the lowest free index is the last one written.
    for (int i = NUM_ENEMIES - 1; i >= 0; i--) begin
      if (!active_i[i]) begin
        idx_o   = IDX_W'(i);
        found_o = 1'b1;
      end
    end
  end

endmodule

// File: rtl/enemy_pool.sv
// Fixed table of enemy slots: allocates on spawn, moves live enemies on a slow tick,
// frees on kill or escape, and reports the live count with zero added latency.
module enemy_pool
  import enemy_pkg::*;
#(
  parameter int X_MIN    = 16,
  parameter int X_STEP   = 38,
  parameter int Y_LIMIT  = 480,
  parameter int SPEED    = 2,
  parameter int MOVE_DIV = 500000
) (
  input  logic         clk,
  input  logic         rst,
  enemy_pool_if.slave  bus
);

  localparam int                TICK_W   = $clog2(MOVE_DIV);
  localparam logic [TICK_W-1:0] TICK_MAX = TICK_W'(MOVE_DIV - 1);

  logic [NUM_ENEMIES-1:0] active_q, active_d;
  logic [X_W-1:0]         x_q [NUM_ENEMIES];
  logic [X_W-1:0]         x_d [NUM_ENEMIES];
  logic [Y_W-1:0]         y_q [NUM_ENEMIES];
  logic [Y_W-1:0]         y_d [NUM_ENEMIES];
  logic [X_W-1:0]         ny  [NUM_ENEMIES];
  logic [TICK_W-1:0]      tick_q, tick_d;
  logic                   escaped_q, escaped_d;

  logic [IDX_W-1:0]       free_idx;
  logic                   free_found;
  logic                   move_tick;
  logic                   alloc;
  logic [X_W-1:0]         spawn_x;

  free_slot_finder u_finder (
    .active_i (active_q),
    .idx_o    (free_idx),
    .found_o  (free_found)
  );

  assign move_tick = bus.enable && (tick_q == TICK_MAX);
  assign alloc     = bus.enable && bus.spawn && free_found;
  assign spawn_x   = X_W'(X_MIN) + X_W'(bus.random_number) * X_W'(X_STEP);

  // Next y is formed one bit wider than stored so the escape compare cannot wrap.
  always_comb begin
    for (int i = 0; i < NUM_ENEMIES; i++) begin
      ny[i] = X_W'(y_q[i]) + X_W'(SPEED);
    end
  end

  always_comb begin
    active_d  = active_q;
    x_d       = x_q;
    y_d       = y_q;
    escaped_d = 1'b0;
    tick_d    = tick_q;

    if (bus.enable) begin
      tick_d = (tick_q == TICK_MAX) ? '0 : tick_q + 1'b1;
    end

    for (int i = 0; i < NUM_ENEMIES; i++) begin
      if (active_q[i]) begin
        if (bus.kill_valid && (bus.kill_idx == IDX_W'(i))) begin
          active_d[i] = 1'b0;
        end else if (move_tick) begin
          if (ny[i] >= X_W'(Y_LIMIT)) begin
            active_d[i] = 1'b0;
            escaped_d   = 1'b1;
          end else begin
            y_d[i] = ny[i][Y_W-1:0];
          end
        end
      end
    end

    // The target is free in the registered mask, so no kill or move touches it this cycle.
    if (alloc) begin
      active_d[free_idx] = 1'b1;
      x_d[free_idx]      = spawn_x;
      y_d[free_idx]      = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      active_q  <= '0;
      tick_q    <= '0;
      escaped_q <= 1'b0;
      for (int i = 0; i < NUM_ENEMIES; i++) begin
        x_q[i] <= '0;
        y_q[i] <= '0;
      end
    end else begin
      active_q  <= active_d;
      tick_q    <= tick_d;
      escaped_q <= escaped_d;
      x_q       <= x_d;
      y_q       <= y_d;
    end
  end

  logic [NUM_ENEMIES*X_W-1:0] x_flat;
  logic [NUM_ENEMIES*Y_W-1:0] y_flat;

  always_comb begin
    x_flat = '0;
    y_flat = '0;
    for (int i = 0; i < NUM_ENEMIES; i++) begin
      x_flat[X_W*i +: X_W] = x_q[i];
      y_flat[Y_W*i +: Y_W] = y_q[i];
    end
  end

  assign bus.enemy_active = active_q;
  assign bus.enemy_x_flat = x_flat;
  assign bus.enemy_y_flat = y_flat;
  assign bus.enemy_count  = popcount(active_q);
  assign bus.escaped      = escaped_q;

endmodule

// File: tb/tb_enemy_pool.sv
// Bench for enemy_pool with a fast movement tick (MOVE_DIV=4): a behavioural model
// pushes the expected output snapshot per driven cycle and each test pops and compares it.
module tb_enemy_pool;
  import enemy_pkg::*;

  typedef logic [164:0] snap_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  enemy_pool_if bus ();

  enemy_pool #(.MOVE_DIV(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int checks   = 0;
  int failures = 0;

  logic [7:0] m_act;
  logic [9:0] m_x [8];
  int         m_y [8];
  int         m_cnt;
  logic       m_esc;
  snap_t      sb_q [$];

  function automatic snap_t model_snap();
    logic [79:0] xf;
    logic [71:0] yf;
    logic [3:0]  n;
    n = 4'd0;
    for (int i = 0; i < 8; i++) begin
      xf[10*i +: 10] = m_x[i];
      yf[9*i +: 9]   = 9'(m_y[i]);
      n = n + 4'(m_act[i]);
    end
    return {m_act, n, m_esc, xf, yf};
  endfunction

  function automatic snap_t obs();
    return {bus.enemy_active, bus.enemy_count, bus.escaped, bus.enemy_x_flat, bus.enemy_y_flat};
  endfunction

  // Drive one clock of stimulus, advance the model, queue the expected snapshot.
  task automatic cycle(input logic r, input logic en, input logic sp, input logic [3:0] rn,
                       input logic kv, input logic [2:0] ki);
    logic [7:0] na;
    logic       ne;
    logic       tick;
    int         fi;
    int         nyv;
    rst = r;
    bus.enable = en;
    bus.spawn = sp;
    bus.random_number = rn;
    bus.kill_valid = kv;
    bus.kill_idx = ki;
    if (r) begin
      m_act = 8'h00;
      m_cnt = 0;
      m_esc = 1'b0;
      for (int i = 0; i < 8; i++) begin
        m_x[i] = 10'd0;
        m_y[i] = 0;
      end
    end else begin
      na = m_act;
      ne = 1'b0;
      tick = en && (m_cnt == 3);
      for (int i = 0; i < 8; i++) begin
        if (m_act[i]) begin
          if (kv && (int'(ki) == i)) begin
            na[i] = 1'b0;
          end else if (tick) begin
            nyv = m_y[i] + 2;
            if (nyv >= 480) begin
              na[i] = 1'b0;
              ne = 1'b1;
            end else begin
              m_y[i] = nyv;
            end
          end
        end
      end
      fi = -1;
      for (int i = 7; i >= 0; i--) if (!m_act[i]) fi = i;
      if (en && sp && fi >= 0) begin
        na[fi] = 1'b1;
        m_x[fi] = 10'(16 + int'(rn) * 38);
        m_y[fi] = 0;
      end
      if (en) m_cnt = (m_cnt == 3) ? 0 : m_cnt + 1;
      m_act = na;
      m_esc = ne;
    end
    sb_q.push_back(model_snap());
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    snap_t e, g;
    for (int c = 0; c < 2; c++) begin
      cycle(1'b1, 1'b1, 1'b1, 4'd3, 1'b0, 3'd0);
      e = sb_q.pop_front(); g = obs(); checks++;
      if (g !== e) begin failures++; $display("FAIL reset c%0d got=%h exp=%h", c, g, e); end
    end
    checks++;
    if (bus.enemy_count !== 4'd0) begin
      failures++; $display("FAIL reset_count got=%0d exp=0", bus.enemy_count);
    end
  endtask

  task automatic test_fill();
    snap_t e, g;
    cycle(1'b1, 1'b0, 1'b0, 4'd0, 1'b0, 3'd0);
    void'(sb_q.pop_front());
    for (int c = 0; c < 10; c++) begin
      cycle(1'b0, 1'b1, 1'b1, 4'd0, 1'b0, 3'd0);
      e = sb_q.pop_front(); g = obs(); checks++;
      if (g !== e) begin failures++; $display("FAIL fill c%0d got=%h exp=%h", c, g, e); end
      checks++;
      if (bus.enemy_count !== 4'((c < 8) ? c + 1 : 8)) begin
        failures++; $display("FAIL fill_count c%0d got=%0d exp=%0d", c, bus.enemy_count, (c < 8) ? c + 1 : 8);
      end
    end
    checks++;
    if (bus.enemy_x_flat[79:70] !== 10'd16) begin
      failures++; $display("FAIL fill_x7 got=%0d exp=16", bus.enemy_x_flat[79:70]);
    end
  endtask

  task automatic test_max_x();
    snap_t e, g;
    cycle(1'b1, 1'b0, 1'b0, 4'd0, 1'b0, 3'd0);
    void'(sb_q.pop_front());
    cycle(1'b0, 1'b1, 1'b1, 4'd15, 1'b0, 3'd0);
    e = sb_q.pop_front(); g = obs(); checks++;
    if (g !== e) begin failures++; $display("FAIL max_x got=%h exp=%h", g, e); end
    checks++;
    if (bus.enemy_x_flat[9:0] !== 10'd586 || bus.enemy_count !== 4'd1) begin
      failures++; $display("FAIL max_x_val got x=%0d cnt=%0d exp x=586 cnt=1", bus.enemy_x_flat[9:0], bus.enemy_count);
    end
  endtask

  task automatic test_move_freeze();
    snap_t e, g;
    logic [8:0] y_hold;
    cycle(1'b1, 1'b0, 1'b0, 4'd0, 1'b0, 3'd0);
    void'(sb_q.pop_front());
    cycle(1'b0, 1'b1, 1'b1, 4'd2, 1'b0, 3'd0);
    void'(sb_q.pop_front());
    for (int c = 0; c < 30; c++) begin
      if (c < 10)      cycle(1'b0, 1'b1, 1'b0, 4'd0, 1'b0, 3'd0);
      else if (c < 20) cycle(1'b0, 1'b0, 1'b1, 4'd0, 1'b0, 3'd0);
      else             cycle(1'b0, 1'b1, 1'b0, 4'd0, 1'b0, 3'd0);
      if (c == 10) y_hold = bus.enemy_y_flat[8:0];
      e = sb_q.pop_front(); g = obs(); checks++;
      if (g !== e) begin failures++; $display("FAIL move c%0d got=%h exp=%h", c, g, e); end
      if (c > 10 && c < 20) begin
        checks++;
        if (bus.enemy_y_flat[8:0] !== y_hold) begin
          failures++; $display("FAIL freeze c%0d got y=%0d exp y=%0d", c, bus.enemy_y_flat[8:0], y_hold);
        end
      end
    end
  endtask

  task automatic test_escape();
    snap_t e, g;
    int pulses = 0;
    int n = 0;
    cycle(1'b1, 1'b0, 1'b0, 4'd0, 1'b0, 3'd0);
    void'(sb_q.pop_front());
    cycle(1'b0, 1'b1, 1'b1, 4'd1, 1'b0, 3'd0);
    void'(sb_q.pop_front());
    while (n < 1100 && (m_act[0] || n < 4 || pulses == 0 || n < 2000 && m_esc)) begin
      cycle(1'b0, 1'b1, 1'b0, 4'd0, 1'b0, 3'd0);
      n++;
      if (bus.escaped === 1'b1) pulses++;
      e = sb_q.pop_front(); g = obs(); checks++;
      if (g !== e) begin failures++; $display("FAIL escape n%0d got=%h exp=%h", n, g, e); end
    end
    for (int c = 0; c < 4; c++) begin
      cycle(1'b0, 1'b1, 1'b0, 4'd0, 1'b0, 3'd0);
      if (bus.escaped === 1'b1) pulses++;
      void'(sb_q.pop_front());
    end
    checks++;
    if (pulses != 1 || bus.enemy_count !== 4'd0) begin
      failures++; $display("FAIL escape_pulse got pulses=%0d cnt=%0d exp pulses=1 cnt=0", pulses, bus.enemy_count);
    end
  endtask

  task automatic test_kill_realloc();
    snap_t e, g;
    cycle(1'b1, 1'b0, 1'b0, 4'd0, 1'b0, 3'd0);
    void'(sb_q.pop_front());
    for (int c = 0; c < 8; c++) begin
      cycle(1'b0, 1'b1, 1'b1, 4'(c), 1'b0, 3'd0);
      void'(sb_q.pop_front());
    end
    cycle(1'b0, 1'b1, 1'b1, 4'd9, 1'b1, 3'd5);
    e = sb_q.pop_front(); g = obs(); checks++;
    if (g !== e) begin failures++; $display("FAIL kill got=%h exp=%h", g, e); end
    checks++;
    if (bus.enemy_active !== 8'hDF) begin
      failures++; $display("FAIL kill_mask got=%h exp=df", bus.enemy_active);
    end
    cycle(1'b0, 1'b1, 1'b1, 4'd7, 1'b1, 3'd2);
    e = sb_q.pop_front(); g = obs(); checks++;
    if (g !== e) begin failures++; $display("FAIL realloc got=%h exp=%h", g, e); end
    checks++;
    if (bus.enemy_active !== 8'hFB || bus.enemy_x_flat[59:50] !== 10'd282) begin
      failures++; $display("FAIL realloc_slot5 got mask=%h x=%0d exp mask=fb x=282", bus.enemy_active, bus.enemy_x_flat[59:50]);
    end
  endtask

  task automatic test_kill_escape();
    snap_t e, g;
    int n = 0;
    cycle(1'b1, 1'b0, 1'b0, 4'd0, 1'b0, 3'd0);
    void'(sb_q.pop_front());
    cycle(1'b0, 1'b1, 1'b1, 4'd4, 1'b0, 3'd0);
    void'(sb_q.pop_front());
    while (n < 1100 && !(m_act[0] && m_y[0] == 478 && m_cnt == 3)) begin
      cycle(1'b0, 1'b1, 1'b0, 4'd0, 1'b0, 3'd0);
      n++;
      void'(sb_q.pop_front());
    end
    checks++;
    if (n >= 1100) begin failures++; $display("FAIL kill_escape_setup got timeout exp y=478"); end
    cycle(1'b0, 1'b1, 1'b0, 4'd0, 1'b1, 3'd0);
    e = sb_q.pop_front(); g = obs(); checks++;
    if (g !== e) begin failures++; $display("FAIL kill_escape got=%h exp=%h", g, e); end
    cycle(1'b0, 1'b1, 1'b0, 4'd0, 1'b0, 3'd0);
    void'(sb_q.pop_front());
    checks++;
    if (bus.escaped !== 1'b0 || bus.enemy_active !== 8'h00) begin
      failures++; $display("FAIL kill_escape_after got esc=%b mask=%h exp esc=0 mask=00", bus.escaped, bus.enemy_active);
    end
  endtask

  task automatic test_reset_mid();
    snap_t e, g;
    cycle(1'b1, 1'b0, 1'b0, 4'd0, 1'b0, 3'd0);
    void'(sb_q.pop_front());
    for (int c = 0; c < 3; c++) begin
      cycle(1'b0, 1'b1, 1'b1, 4'd11, 1'b0, 3'd0);
      void'(sb_q.pop_front());
    end
    cycle(1'b1, 1'b1, 1'b1, 4'd11, 1'b1, 3'd1);
    e = sb_q.pop_front(); g = obs(); checks++;
    if (g !== e) begin failures++; $display("FAIL reset_mid got=%h exp=%h", g, e); end
    checks++;
    if (g !== '0) begin failures++; $display("FAIL reset_mid_zero got=%h exp=0", g); end
  endtask

  initial begin
    m_act = 8'h00;
    m_cnt = 0;
    m_esc = 1'b0;
    for (int i = 0; i < 8; i++) begin
      m_x[i] = 10'd0;
      m_y[i] = 0;
    end
    rst = 1'b1;
    bus.enable = 1'b0;
    bus.spawn = 1'b0;
    bus.random_number = 4'd0;
    bus.kill_valid = 1'b0;
    bus.kill_idx = 3'd0;
    @(negedge clk);
    test_reset();
    test_fill();
    test_max_x();
    test_move_freeze();
    test_escape();
    test_kill_realloc();
    test_kill_escape();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/enemy_pool.md
Name: enemy_pool

Overview:
Downstream consumer of the spawner's spawn request. Owns the fixed table of 8 enemy slots and does four jobs: allocates a free slot on spawn, steps every live enemy down the screen on a slow movement tick, frees slots on kill or escape, and reports the live count. That live count is the enemy_count the spawner consumes. The slot table feeds the renderer and the collision detector.

Parameters:
X_MIN, 16, leftmost spawn x in pixels
X_STEP, 38, x spacing per random_number unit; spawn x = X_MIN + random_number*X_STEP, max 586
Y_LIMIT, 480, y at or beyond which an enemy has escaped
SPEED, 2, pixels added to y per movement tick
MOVE_DIV, 500000, clocks per movement tick (>= 2)

Ports:
clk  in  1  system clock, single domain
rst  in  1  synchronous reset, active-high
enable  in  1  game running; 0 freezes movement and allocation
spawn  in  1  level request from spawner; one allocation per clk while high
random_number  in  4  spawn column select, sampled in the allocation cycle
kill_valid  in  1  collision detector reports a hit this cycle
kill_idx  in  3  slot index hit
enemy_active  out  8  bit i = slot i live
enemy_x_flat  out  80  slot i x at [10*i+9:10*i]
enemy_y_flat  out  72  slot i y at [9*i+8:9*i]
enemy_count  out  4  popcount(enemy_active), 0..8
escaped  out  1  one-cycle pulse when >=1 enemy left via Y_LIMIT

Behaviour:
- Reset, on a clk edge with rst=1: active=0, all x/y=0, tick counter=0, escaped=0. enemy_count is therefore 0 on the cycle after reset. rst overrides all other inputs in that cycle.
- enemy_count is combinational from registered enemy_active, so it has zero added latency. A slot change at edge N is visible in the count after edge N.
- Tick counter:
  - Counts 0..MOVE_DIV-1 only while enable=1, and holds while enable=0.
  - move_tick is asserted in the cycle the counter equals MOVE_DIV-1; the counter then wraps to 0.
- Allocation, in a cycle with enable & spawn & (active != 8'hFF):
  - Target is the lowest-index slot with active=0, taken from the registered mask.
  - That slot gets active=1, x=X_MIN+random_number*X_STEP computed in 10 bits, y=0.
  - When all 8 slots are live, the request is ignored with no error.
  - At most one allocation per cycle. A held spawn fills one slot per clk.
- Kill, in a cycle with kill_valid=1:
  - Clears active[kill_idx]. x and y are left stale.
  - Applies regardless of enable.
  - A kill on an already-inactive slot does nothing.
- Movement, on move_tick: for every active slot, ny = y + SPEED computed in 10 bits.
  - If ny >= Y_LIMIT, the slot is cleared and escaped is pulsed on the next cycle.
  - Otherwise y <= ny[8:0].
- Simultaneous events, by priority:
  - Kill beats move and escape on the same slot; no escaped pulse is produced for that slot.
  - A slot freed in cycle N (by kill or escape) is not allocatable until cycle N+1, because allocation uses the pre-edge mask.
  - An allocation and a move in the same cycle: the newly allocated slot is not moved, and it enters with y=0.
  - Allocation and a kill of a different slot in the same cycle: both take effect.
- escaped is registered: high for exactly one cycle per tick that has any escape, and low otherwise.
- The state machine per slot is implicit: FREE -> LIVE on allocate; LIVE -> FREE on kill or escape; no other states.

Decomposition:
- Shared package enemy_pkg holds:
  - NUM_ENEMIES=8
  - X_W=10, Y_W=9
  - SCREEN_W=640, SCREEN_H=480
  - slot-index width 3
- The spawner and the renderer import the same constants.
- One sub-module: free_slot_finder. It is combinational and maps the 8-bit active mask to the lowest free index plus a found flag.

Test Plan:
- Reset then spawn held high 10 cycles, random_number=0 -> slots 0..7 filled in order, each x=16, y=0. enemy_count goes 1..8, then stays 8; no further change.
- random_number=15, single spawn cycle -> slot 0 x=586, enemy_count=1 on the next cycle.
- MOVE_DIV=4, SPEED=2, one enemy -> y increments 0,2,4 every 4 clks. With enable=0 for 10 clks, y and the counter freeze.
- Set y=478 by ticking, then on the next tick -> slot cleared, escaped high exactly 1 cycle, enemy_count decrements.
- Full pool, kill_idx=5 with spawn high the same cycle -> slot 5 freed. Slot 5 is reallocated on the following cycle, not the same one.
- kill_valid on the escaping slot in the move_tick cycle -> slot cleared, escaped stays 0. rst asserted mid-fill -> all outputs 0 on the next cycle.
